// File: rtl/logic_analyzer_fsm.sv
// Capture controller for sample_mem: clear, pre-fill, slide window, fill.
// Ports: clk/rst_n, trig, size in; acquire/pop/clear out; 16-bit bus in/out.
module logic_analyzer_fsm #(
  parameter  int BASE_ADDR       = 0,
  parameter  int SAMPLE_DEPTH    = 0,
  localparam int BRAM_ADDR_WIDTH = $clog2(SAMPLE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig,
  input  logic [BRAM_ADDR_WIDTH:0] size,
  output logic                     acquire,
  output logic                     pop,
  output logic                     clear,
  input  logic [15:0]              addr_i,
  input  logic [15:0]              wdata_i,
  input  logic [15:0]              rdata_i,
  input  logic                     rw_i,
  input  logic                     valid_i,
  output logic [15:0]              addr_o,
  output logic [15:0]              wdata_o,
  output logic [15:0]              rdata_o,
  output logic                     rw_o,
  output logic                     valid_o
);

  localparam int W = BRAM_ADDR_WIDTH + 1;
  localparam logic [W-1:0] DEPTH  = W'(SAMPLE_DEPTH);
  localparam logic [W-1:0] LAST   = W'(SAMPLE_DEPTH - 1);
  localparam logic [W-1:0] HALF   = W'(SAMPLE_DEPTH / 2);
  localparam logic [15:0]  LAST16 = 16'(SAMPLE_DEPTH - 1);
  localparam logic [15:0]  BASE   = 16'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    MOVE_TO_POSITION = 3'd1,
    IN_POSITION      = 3'd2,
    FILLING          = 3'd3,
    FILLED           = 3'd4
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] trig_loc;
  logic [15:0]  offset;
  logic [15:0]  reg_val;
  logic         hit;
  logic         wr;
  logic         rd;
  logic         armable;
  logic         start;
  logic         stop;
  logic         loc_wr;

  // Wrapping subtract keeps the window check correct for any base.
  assign offset  = addr_i - BASE;
  assign hit     = valid_i && (offset < 16'd4);
  assign wr      = hit && rw_i;
  assign rd      = hit && !rw_i;
  assign armable = (state == IDLE) || (state == FILLED);
  assign start   = wr && (offset[1:0] == 2'd2) && armable;
  assign stop    = wr && (offset[1:0] == 2'd3);
  assign loc_wr  = wr && (offset[1:0] == 2'd1) && armable;

  always_comb begin
    unique case (offset[1:0])
      2'd0:    reg_val = 16'(state);
      2'd1:    reg_val = 16'(trig_loc);
      default: reg_val = 16'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    acquire  = 1'b0;
    pop      = 1'b0;
    // The clear cycle freezes the FSM while the FIFO empties.
    if (!clear) begin
      unique case (state)
        MOVE_TO_POSITION: begin
          acquire = 1'b1;
          if (size == trig_loc - W'(1)) state_nx = IN_POSITION;
        end
        IN_POSITION: begin
          acquire = (trig_loc != '0) || trig;
          pop     = (trig_loc != '0) && !trig;
          if (trig) state_nx = FILLING;
        end
        FILLING: begin
          acquire = (size < DEPTH);
          if (size >= LAST) state_nx = FILLED;
        end
        IDLE, FILLED: ;
        default: state_nx = IDLE;
      endcase
    end
    if (start) begin
      state_nx = (trig_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
    end
    if (stop) state_nx = IDLE;
    if (!rst_n) begin
      acquire = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      trig_loc <= HALF;
      clear    <= 1'b0;
      addr_o   <= 16'd0;
      wdata_o  <= 16'd0;
      rdata_o  <= 16'd0;
      rw_o     <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      state <= state_nx;
      clear <= start;
      if (loc_wr) begin
        trig_loc <= (wdata_i > LAST16) ? LAST : wdata_i[W-1:0];
      end
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      rdata_o <= rd ? reg_val : rdata_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
    end
  end

endmodule

// File: doc/logic_analyzer_fsm.md
# logic_analyzer_fsm

Capture controller for the logic-analyzer core. It sequences `sample_mem` through a complete acquisition:
- clear the FIFO;
- pre-fill a programmable pre-trigger window;
- slide that window while waiting for the trigger;
- fill the remaining depth and stop.

It drives the FIFO's `acquire`/`pop`/`clear` controls from its own state and the FIFO `size`. It sits on the daisy-chained register bus ahead of `sample_mem`, and exposes control and status registers there.

## Interface
Parameters:
- `BASE_ADDR`, 0: first of 4 bus registers owned by this block.
- `SAMPLE_DEPTH`, 0: must equal the `sample_mem` depth, ≥ 2.
- `BRAM_ADDR_WIDTH`, `$clog2(SAMPLE_DEPTH)`: localparam, not overridable.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `trig`  in  1  trigger condition, same clock domain.
- `size`  in  BRAM_ADDR_WIDTH+1  current FIFO occupancy from `sample_mem`.
- `acquire`  out  1  to `sample_mem`, combinational from state, `size`, `trig`.
- `pop`  out  1  to `sample_mem`, combinational.
- `clear`  out  1  to `sample_mem`, registered.
- `addr_i`, `wdata_i`, `rdata_i`  in  16 each  bus input.
- `rw_i`, `valid_i`  in  1 each  bus input; `rw_i` = 1 means write.
- `addr_o`, `wdata_o`, `rdata_o`  out  16 each  bus output, registered.
- `rw_o`, `valid_o`  out  1 each  bus output, registered.

## Operation
Register map (offsets from `BASE_ADDR`):
- +0 STATE, read-only: 0 IDLE, 1 MOVE_TO_POSITION, 2 IN_POSITION, 3 FILLING, 4 FILLED.
- +1 TRIGGER_LOC, read/write, reset value `SAMPLE_DEPTH/2`.
  - Writes are accepted only in IDLE or FILLED; ignored otherwise.
  - Written values above `SAMPLE_DEPTH-1` saturate to `SAMPLE_DEPTH-1`.
- +2 START, write-only (reads return 0): any write in IDLE or FILLED arms a capture; ignored in other states.
- +3 STOP, write-only (reads return 0): any write in any state forces IDLE on the next edge.

Bus behaviour:
- Every bus input is copied to its output with 1 cycle of latency.
- `rdata_o` is replaced by register contents when `valid_i && !rw_i` and `addr_i` is in `BASE_ADDR..BASE_ADDR+3`; all other traffic passes through unchanged.

On an accepted START:
- next state is MOVE_TO_POSITION, or IN_POSITION if TRIGGER_LOC = 0;
- `clear` is 1 for exactly the following cycle (the "clear cycle");
- during the clear cycle `acquire` = `pop` = 0 and no transitions are taken.

Per-state outputs and transitions (all apply outside the clear cycle):
- IDLE: `acquire` = `pop` = 0.
- MOVE_TO_POSITION: `acquire` = 1, `pop` = 0. Go to IN_POSITION when `size == TRIGGER_LOC-1`. `trig` is ignored in this state.
- IN_POSITION:
  - `acquire` = (TRIGGER_LOC≠0) || `trig`.
  - `pop` = (TRIGGER_LOC≠0) && !`trig`. This holds the window at exactly TRIGGER_LOC samples.
  - Go to FILLING when `trig` = 1. The trigger-cycle sample is stored without a pop, so it lands at FIFO index TRIGGER_LOC.
- FILLING: `acquire` = (`size < SAMPLE_DEPTH`), `pop` = 0. Go to FILLED when `size >= SAMPLE_DEPTH-1`.
- FILLED: `acquire` = `pop` = 0. Hold until START or STOP. Host reads capture data from `sample_mem`.

Other rules:
- STOP takes priority over every transition.
- Only one bus transaction per cycle, so START and STOP cannot coincide.
- All `size` comparisons are unsigned at width BRAM_ADDR_WIDTH+1.

## Timing
Reset (`rst_n` low at a posedge):
- state becomes IDLE and TRIGGER_LOC becomes `SAMPLE_DEPTH/2`;
- `clear` and all bus outputs become 0.

Reset mid-operation:
- `acquire` and `pop` are gated by `rst_n`, so both are 0 in any cycle where `rst_n` = 0.
- No FIFO write or pop occurs during reset.
- FIFO contents are not cleared by reset.

START latency, with the START write at cycle c:
- c+1: clear cycle.
- c+2: first `acquire`, with `size` = 0.
- With TRIGGER_LOC = L ≥ 1, IN_POSITION is reached at c+2+L with `size` = L.

Trigger latency, with `trig` at cycle t in IN_POSITION:
- that cycle's sample is stored;
- STATE reads FILLING from t+1;
- FILLED is reached once `size` = `SAMPLE_DEPTH`.

STOP: the write at cycle s gives IDLE at s+1, and `acquire`/`pop` = 0 from s+1. FIFO contents and pointers are untouched.

## Test plan
All scenarios use `SAMPLE_DEPTH` = 8, `BASE_ADDR` = 0.
1. Reset with `rst_n` low for 2 cycles → STATE reads 0, TRIGGER_LOC reads 4, `clear`/`acquire`/`pop` = 0, bus outputs 0.
2. Write TRIGGER_LOC = 3, START at cycle c, `trig` pulsed 5 cycles after IN_POSITION is reached → `clear` = 1 only at c+1, IN_POSITION at c+5 with `size` = 3, `size` stays 3 until the trigger, FILLED with `size` = 8, stored word at index 3 equals the trigger-cycle sample.
3. TRIGGER_LOC = 0 → START goes directly to IN_POSITION, `acquire` = 0 until `trig`, trigger sample lands at index 0, FILLED with `size` = 8.
4. Write TRIGGER_LOC = 20 → reads back 7; a `trig` in the first IN_POSITION cycle gives FILLED after 1 more sample.
5. STOP written during FILLING, then TRIGGER_LOC write during MOVE_TO_POSITION → STOP gives STATE = 0 next cycle with `acquire` low; the write during MOVE_TO_POSITION leaves TRIGGER_LOC unchanged.
6. Bus pass-through: reads at addr 0x0010 and writes anywhere → outputs equal inputs delayed by 1 cycle. A read at addr 0 in FILLED → `rdata_o` = 4 one cycle later.
